// File: rtl/pll_spi_config_pkg.sv
// pll_spi_config_pkg
// Definitions shared by the CDCE62002 programming block. This package takes
// the place of the cdce62002_defs.vh header and holds:
//   - register address nibbles: REG0_ADDR, REG1_ADDR, READ_CMD_ADDR
//   - frame sizing: FRAME_BITS (shift length), GAP_CYCLES (cs-high gap)
//   - the state encoding (pll_state_e) and the frame slot indices
//   - helpers that build the read command and select the word for each frame
package pll_spi_config_pkg;

  localparam logic [3:0] REG0_ADDR     = 4'h0;
  localparam logic [3:0] REG1_ADDR     = 4'h1;
  localparam logic [3:0] READ_CMD_ADDR = 4'hE;

  localparam int FRAME_BITS = 32;
  localparam int GAP_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } pll_state_e;

  // Fixed frame order. A write-only sequence stops after FR_W1.
  localparam logic [2:0] FR_W0     = 3'd0;
  localparam logic [2:0] FR_W1     = 3'd1;
  localparam logic [2:0] FR_R0CMD  = 3'd2;
  localparam logic [2:0] FR_R0DATA = 3'd3;
  localparam logic [2:0] FR_R1CMD  = 3'd4;
  localparam logic [2:0] FR_R1DATA = 3'd5;

  function automatic logic [31:0] read_cmd(input logic [1:0] regnum);
    return {26'b0, regnum, READ_CMD_ADDR};
  endfunction

  // Readback data frames shift out zeros while the PLL drives miso.
  function automatic logic [31:0] frame_word(input logic [2:0]  idx,
                                             input logic [31:0] r0,
                                             input logic [31:0] r1);
    logic [31:0] w;
    w = 32'h0;
    case (idx)
      FR_W0:    w = r0;
      FR_W1:    w = r1;
      FR_R0CMD: w = read_cmd(2'd0);
      FR_R1CMD: w = read_cmd(2'd1);
      default:  w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pll_spi_config_spi_shift32.sv
// spi_shift32
// 32-bit LSB-first shifter with SCLK phase generator, bit counter and a
// miso capture register. The sequencer in pll_spi_config decides when to
// load and when to run; this block only walks the bits of one frame.
// Ports:
//   sysclk, reset_INV     clock, async active-low reset
//   load, load_word       load a new frame word, clear phase/counter/capture
//   run                   advance one SCLK phase per cycle
//   miso                  sampled as phase 1 is left (the SCLK rising edge at the pin)
//   phase                 0 = SCLK low half, 1 = SCLK high half
//   mosi_bit              current outgoing bit
//   shift_done            last cycle of bit 31
//   capture               miso bits, first received bit in [0]
module spi_shift32
  import pll_spi_config_pkg::*;
(
  input  logic        sysclk,
  input  logic        reset_INV,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        run,
  input  logic        miso,
  output logic        phase,
  output logic        mosi_bit,
  output logic        shift_done,
  output logic [31:0] capture
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic [31:0] shreg;
  logic [4:0]  bit_cnt;

  assign mosi_bit   = shreg[0];
  assign shift_done = run && phase && (bit_cnt == LAST_BIT);

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      shreg   <= 32'h0;
      capture <= 32'h0;
      bit_cnt <= 5'd0;
      phase   <= 1'b0;
    end else if (load) begin
      shreg   <= load_word;
      capture <= 32'h0;
      bit_cnt <= 5'd0;
      phase   <= 1'b0;
    end else if (run) begin
      if (!phase) begin
        phase <= 1'b1;
      end else begin
        phase   <= 1'b0;
        shreg   <= {1'b0, shreg[31:1]};
        capture <= {miso, capture[31:1]};
        // Holds at 31 after the final bit instead of wrapping.
        if (bit_cnt != LAST_BIT) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pll_spi_config.sv
// pll_spi_config
// Programs the CDCE62002 PLL over its SPI-like port: writes register 0 and 1
// and optionally reads both back and compares bits [31:4].
// Handshake: start is a one-cycle request, accepted only in IDLE, DONE or
// ERROR (verify_en is captured with it); busy/done/error are levels, and
// done/error stay until the next accepted start.
// All pins and status flags are registered copies of the state, so they
// follow the state register by one cycle and never glitch.
// Ports:
//   sysclk, reset_INV               clock, async active-low reset
//   start, verify_en                request, readback enable
//   reg0_word, reg1_word            register images (stable while busy)
//   busy, done, error               status
//   pll_spi_clk/mosi/cs_INV, miso   PLL serial port
//   dbg_state                       current sequencer state
module pll_spi_config
  import pll_spi_config_pkg::*;
(
  input  logic        sysclk,
  input  logic        reset_INV,
  input  logic        start,
  input  logic        verify_en,
  input  logic [31:0] reg0_word,
  input  logic [31:0] reg1_word,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        pll_spi_clk,
  output logic        pll_spi_mosi,
  output logic        pll_spi_cs_INV,
  input  logic        pll_spi_miso,
  output pll_state_e  dbg_state
);

  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

  pll_state_e  state, next_state;
  logic [2:0]  frame_idx, next_frame;
  logic [1:0]  gap_cnt;
  logic        verify_q, next_verify;
  logic        load;
  logic [31:0] load_word;
  logic        phase, mosi_bit, shift_done;
  logic [31:0] capture;
  logic [2:0]  last_frame;
  logic        is_data_frame;
  logic        mismatch;
  logic        cs_active;

  spi_shift32 u_shift (
    .sysclk     (sysclk),
    .reset_INV  (reset_INV),
    .load       (load),
    .load_word  (load_word),
    .run        (state == ST_SHIFT),
    .miso       (pll_spi_miso),
    .phase      (phase),
    .mosi_bit   (mosi_bit),
    .shift_done (shift_done),
    .capture    (capture)
  );

  assign last_frame    = verify_q ? FR_R1DATA : FR_W1;
  assign is_data_frame = (frame_idx == FR_R0DATA) || (frame_idx == FR_R1DATA);
  // Address nibble is excluded: the device may report it differently.
  assign mismatch = (frame_idx == FR_R0DATA) ? (capture[31:4] != reg0_word[31:4])
                                             : (capture[31:4] != reg1_word[31:4]);
  assign cs_active = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign load_word = frame_word(next_frame, reg0_word, reg1_word);
  assign dbg_state = state;

  always_comb begin
    next_state  = state;
    next_frame  = frame_idx;
    next_verify = verify_q;
    load        = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          next_state  = ST_SETUP;
          next_frame  = FR_W0;
          next_verify = verify_en;
          load        = 1'b1;
        end
      end
      ST_SETUP: next_state = ST_SHIFT;
      ST_SHIFT: if (shift_done) next_state = ST_HOLD;
      ST_HOLD:  next_state = ST_GAP;
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (is_data_frame) begin
            next_state = ST_CHECK;
          end else if (frame_idx == last_frame) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_SETUP;
            next_frame = frame_idx + 3'd1;
            load       = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          next_state = ST_ERROR;
        end else if (frame_idx == last_frame) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_SETUP;
          next_frame = frame_idx + 3'd1;
          load       = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state     <= ST_IDLE;
      frame_idx <= 3'd0;
      gap_cnt   <= 2'd0;
      verify_q  <= 1'b0;
    end else begin
      state     <= next_state;
      frame_idx <= next_frame;
      verify_q  <= next_verify;
      gap_cnt   <= (state == ST_GAP && next_state == ST_GAP) ? gap_cnt + 2'd1 : 2'd0;
    end
  end

  // Registered pins: cs rises and clk falls asynchronously on reset.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      pll_spi_cs_INV <= 1'b1;
      pll_spi_clk    <= 1'b0;
      pll_spi_mosi   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      pll_spi_cs_INV <= !cs_active;
      pll_spi_clk    <= (state == ST_SHIFT) && phase;
      pll_spi_mosi   <= cs_active ? mosi_bit : 1'b0;
      busy           <= !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
      done           <= (state == ST_DONE);
      error          <= (state == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_pll_spi_config.sv
// tb_pll_spi_config
// Bench for pll_spi_config with a behavioural CDCE62002 model that latches
// written words, answers read commands and records every frame.
module tb_pll_spi_config;
  import pll_spi_config_pkg::*;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        reset_INV, start, verify_en;
  logic [31:0] reg0_word, reg1_word;
  logic        busy, done, error;
  logic        pll_spi_clk, pll_spi_mosi, pll_spi_cs_INV, pll_spi_miso;
  pll_state_e  dbg_state;

  pll_spi_config dut (
    .sysclk         (sysclk),
    .reset_INV      (reset_INV),
    .start          (start),
    .verify_en      (verify_en),
    .reg0_word      (reg0_word),
    .reg1_word      (reg1_word),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .pll_spi_clk    (pll_spi_clk),
    .pll_spi_mosi   (pll_spi_mosi),
    .pll_spi_cs_INV (pll_spi_cs_INV),
    .pll_spi_miso   (pll_spi_miso),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- PLL model ----------------
  logic [31:0] got_word  [64];
  int          got_edges [64];
  int          got_n;
  logic [31:0] model_reg [2];
  logic [31:0] rb_xor0, rb_xor1;

  initial begin
    logic        prev_cs, prev_clk, rd_pending, rd_active;
    logic [31:0] sh, rd_val;
    logic [1:0]  rd_reg;
    int          edges, bidx;
    pll_spi_miso = 1'b0;
    got_n = 0;
    model_reg[0] = 32'h0;
    model_reg[1] = 32'h0;
    prev_cs = 1'b1; prev_clk = 1'b0; rd_pending = 1'b0; rd_active = 1'b0;
    sh = 32'h0; rd_val = 32'h0; rd_reg = 2'd0; edges = 0; bidx = 0;
    forever begin
      @(pll_spi_cs_INV or pll_spi_clk);
      if (prev_cs === 1'b1 && pll_spi_cs_INV === 1'b0) begin
        sh = 32'h0;
        edges = 0;
        if (rd_pending) begin
          rd_active = 1'b1;
          rd_pending = 1'b0;
          rd_val = model_reg[rd_reg[0]] ^ (rd_reg[0] ? rb_xor1 : rb_xor0);
          pll_spi_miso = rd_val[0];
          bidx = 1;
        end else begin
          rd_active = 1'b0;
          pll_spi_miso = 1'b0;
        end
      end
      if (pll_spi_cs_INV === 1'b0 && prev_clk === 1'b0 && pll_spi_clk === 1'b1) begin
        sh = {pll_spi_mosi, sh[31:1]};
        edges++;
      end
      if (pll_spi_cs_INV === 1'b0 && prev_clk === 1'b1 && pll_spi_clk === 1'b0
          && rd_active && bidx < 32) begin
        pll_spi_miso = rd_val[bidx];
        bidx++;
      end
      if (prev_cs === 1'b0 && pll_spi_cs_INV === 1'b1) begin
        pll_spi_miso = 1'b0;
        if (reset_INV === 1'b1) begin
          got_word[got_n % 64]  = sh;
          got_edges[got_n % 64] = edges;
          got_n++;
          if (!rd_active && edges == 32) begin
            if (sh[3:0] == REG0_ADDR) model_reg[0] = sh;
            else if (sh[3:0] == REG1_ADDR) model_reg[1] = sh;
            else if (sh[3:0] == READ_CMD_ADDR) begin
              rd_pending = 1'b1;
              rd_reg = sh[5:4];
            end
          end
        end else begin
          rd_pending = 1'b0;
        end
        rd_active = 1'b0;
      end
      prev_cs  = pll_spi_cs_INV;
      prev_clk = pll_spi_clk;
    end
  end

  // ---------------- checks / drivers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  typedef struct {
    string       tag;
    logic        verify;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] x0;
    logic [31:0] x1;
    int          extra_start;
    int          exp_cyc;
    logic        exp_err;
  } vec_t;

  task automatic compare_frames(input string tag, input int base);
    check({tag, "_frames"}, 32'(got_n - base), 32'(exp_q.size()));
    for (int i = base; i < got_n && exp_q.size() > 0; i++) begin
      logic [31:0] w;
      w = exp_q.pop_front();
      check($sformatf("%s_word%0d", tag, i - base), got_word[i % 64], w);
      check($sformatf("%s_clks%0d", tag, i - base), 32'(got_edges[i % 64]), 32'd32);
    end
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int   base, n;
    logic finished;
    reg0_word = v.r0;
    reg1_word = v.r1;
    verify_en = v.verify;
    rb_xor0   = v.x0;
    rb_xor1   = v.x1;
    exp_q.push_back(v.r0);
    exp_q.push_back(v.r1);
    if (v.verify) begin
      exp_q.push_back(32'h0000000E);
      exp_q.push_back(32'h0);
      if (v.x0[31:4] == 28'h0) begin
        exp_q.push_back(32'h0000001E);
        exp_q.push_back(32'h0);
      end
    end
    base = got_n;
    @(negedge sysclk);
    start = 1'b1;
    @(posedge sysclk);
    #1;
    start = 1'b0;
    verify_en = ~v.verify;
    n = 0;
    finished = 1'b0;
    while (!finished && n < 600) begin
      @(posedge sysclk);
      n++;
      #1;
      if (n == 1)
        check({v.tag, "_accept"}, 32'({busy, done, error}), 32'b100);
      if (done || error) finished = 1'b1;
      else if (v.extra_start != 0) begin
        if (n == v.extra_start) start = 1'b1;
        if (n == v.extra_start + 1) start = 1'b0;
      end
    end
    start = 1'b0;
    check({v.tag, "_latency"}, 32'(n), 32'(v.exp_cyc));
    repeat (10) @(posedge sysclk);
    #1;
    check({v.tag, "_final"}, 32'({busy, done, error, pll_spi_cs_INV, pll_spi_clk}),
          32'({1'b0, !v.exp_err, v.exp_err, 1'b1, 1'b0}));
    compare_frames(v.tag, base);
  endtask

  task automatic reset_mid_shift();
    int   base, n;
    logic idle_bad;
    reg0_word = 32'hA5A5A5A0;
    reg1_word = 32'h5A5A5A51;
    verify_en = 1'b0;
    exp_q.push_back(32'hA5A5A5A0);
    base = got_n;
    @(negedge sysclk);
    start = 1'b1;
    @(posedge sysclk);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 107) begin
      @(posedge sysclk);
      n++;
    end
    #1;
    // Bit 17 of W1, SCLK high half.
    check("rst_pre_clk", 32'({pll_spi_cs_INV, pll_spi_clk}), 32'b01);
    reset_INV = 1'b0;
    #1;
    check("rst_pins", 32'({pll_spi_cs_INV, pll_spi_clk, pll_spi_mosi, busy, done, error}),
          32'b100000);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge sysclk);
    reset_INV = 1'b1;
    idle_bad = 1'b0;
    repeat (20) begin
      @(posedge sysclk);
      #1;
      if (pll_spi_cs_INV !== 1'b1 || pll_spi_clk !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || error !== 1'b0)
        idle_bad = 1'b1;
    end
    check("rst_idle_after", 32'(idle_bad), 32'd0);
    compare_frames("rst", base);
  endtask

  // ---------------- main ----------------
  vec_t vecs[8];

  initial begin
    logic [31:0] t0, t1;
    reset_INV = 1'b0;
    start     = 1'b0;
    verify_en = 1'b0;
    reg0_word = 32'h0;
    reg1_word = 32'h0;
    rb_xor0   = 32'h0;
    rb_xor1   = 32'h0;

    t0 = $urandom();
    t1 = $urandom();
    //         tag          ver  reg0                     reg1                     xor0          xor1          extra cyc  err
    vecs[0] = '{"wr",       1'b0, 32'hA5A5A5A0,            32'h5A5A5A51,            32'h0,        32'h0,        0,    141, 1'b0};
    vecs[1] = '{"vpass",    1'b1, 32'hA5A5A5A0,            32'h5A5A5A51,            32'h0,        32'h0,        0,    423, 1'b0};
    vecs[2] = '{"vfail0",   1'b1, 32'hA5A5A5A0,            32'h5A5A5A51,            32'h00000010, 32'h0,        0,    282, 1'b1};
    vecs[3] = '{"busystart",1'b0, 32'hA5A5A5A0,            32'h5A5A5A51,            32'h0,        32'h0,        50,   141, 1'b0};
    vecs[4] = '{"restart",  1'b0, 32'hA5A5A5A0,            32'h5A5A5A51,            32'h0,        32'h0,        0,    141, 1'b0};
    vecs[5] = '{"gapstart", 1'b0, {t0[31:4], 4'h0},        {t1[31:4], 4'h1},        32'h0,        32'h0,        139,  141, 1'b0};
    vecs[6] = '{"nibble",   1'b1, {t1[31:4], 4'h0},        {t0[31:4], 4'h1},        32'h0000000F, 32'h0000000A, 0,    423, 1'b0};
    vecs[7] = '{"vfail1",   1'b1, {t0[31:4], 4'h0},        {t1[31:4], 4'h1},        32'h0,        32'h80000000, 0,    423, 1'b1};

    repeat (3) @(posedge sysclk);
    #1;
    check("reset_pins", 32'({pll_spi_cs_INV, pll_spi_clk, pll_spi_mosi, busy, done, error}),
          32'b100000);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge sysclk);
    reset_INV = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    check("release_idle", 32'({pll_spi_cs_INV, busy, done, error}), 32'b1000);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    reset_mid_shift();
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
